// File: rtl/led_pwm_panel.sv
// Memory-mapped LED panel: per-LED enable, PWM brightness and blink, with
// registered readback of every register over the 19-bit CPU bus.
module led_pwm_panel #(
  parameter logic [18:0] BASE_ADDR  = 19'h5c00,
  parameter int unsigned NUM_LEDS   = 8,
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [18:0]         address,
  input  logic                write_en,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;
  localparam logic [PWM_BITS-1:0] BRIGHT_MAX = '1;

  logic [NUM_LEDS-1:0]   enable_q, enable_d;
  logic [NUM_LEDS-1:0]   blink_q, blink_d;
  logic [PWM_BITS-1:0]   bright_q [NUM_LEDS];
  logic [PWM_BITS-1:0]   bright_d [NUM_LEDS];
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic [NUM_LEDS-1:0]   leds_q, leds_d;
  logic [DATA_W-1:0]     data_out_q, data_out_d;

  logic [ADDR_W-1:0]     offset;
  logic [NUM_LEDS-1:0]   duty_on;
  logic                  blink_off;

  assign offset    = address - BASE_ADDR;
  assign blink_off = blink_cnt_q[BLINK_BITS-1];

  // Full-scale brightness is forced on so max means "always lit", not max-1/2^N.
  always_comb begin
    duty_on = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      duty_on[i] = (bright_q[i] == BRIGHT_MAX) || (pwm_cnt_q < bright_q[i]);
    end
  end

  always_comb begin
    enable_d    = enable_q;
    blink_d     = blink_q;
    bright_d    = bright_q;
    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
    data_out_d  = '0;
    leds_d      = '0;

    // Read mux sees pre-write contents, so a same-edge write returns old data.
    if (offset == ADDR_W'(0)) begin
      data_out_d = DATA_W'(enable_q);
    end else if (offset == ADDR_W'(1)) begin
      data_out_d = DATA_W'(blink_q);
    end
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (offset == ADDR_W'(i + 2)) begin
        data_out_d = DATA_W'(bright_q[i]);
      end
    end

    if (write_en) begin
      if (offset == ADDR_W'(0)) begin
        enable_d = data_in[NUM_LEDS-1:0];
      end else if (offset == ADDR_W'(1)) begin
        blink_d = data_in[NUM_LEDS-1:0];
      end
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        if (offset == ADDR_W'(i + 2)) begin
          bright_d[i] = data_in[PWM_BITS-1:0];
        end
      end
    end

    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      leds_d[i] = enable_q[i] & duty_on[i] & ~(blink_q[i] & blink_off);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enable_q    <= '0;
      blink_q     <= '0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      leds_q      <= '0;
      data_out_q  <= '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        bright_q[i] <= BRIGHT_MAX;
      end
    end else begin
      enable_q    <= enable_d;
      blink_q     <= blink_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      leds_q      <= leds_d;
      data_out_q  <= data_out_d;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        bright_q[i] <= bright_d[i];
      end
    end
  end

  assign data_out = data_out_q;
  assign leds     = leds_q;

endmodule

// File: tb/tb_led_pwm_panel.sv
// Scoreboard bench for led_pwm_panel: a cycle model predicts data_out/leds per
// edge; directed windows check duty counts, blink halves and readback values.
module tb_led_pwm_panel;

  logic        clock;
  logic        reset;
  logic [18:0] address;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [7:0]  leds;

  led_pwm_panel #(
    .BASE_ADDR (19'h5c00),
    .NUM_LEDS  (8),
    .PWM_BITS  (4),
    .BLINK_BITS(6)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .write_en(write_en),
    .data_in (data_in),
    .data_out(data_out),
    .leds    (leds)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state of the peripheral as seen from the bus.
  logic [7:0] m_en, m_bl, m_leds, m_dout;
  logic [3:0] m_br [8];
  logic [3:0] m_pwm;
  logic [5:0] m_blk;

  logic [15:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [18:0] a, input logic w, input logic [7:0] d);
    logic [18:0] off;
    logic [7:0]  rd;
    logic        duty;
    int          idx;
    if (r) begin
      m_en = '0; m_bl = '0; m_pwm = '0; m_blk = '0; m_leds = '0; m_dout = '0;
      for (int i = 0; i < 8; i++) m_br[i] = 4'hF;
      return;
    end
    off = a - 19'h5c00;
    idx = int'(off) - 2;
    rd  = 8'h00;
    if (off == 19'd0) rd = m_en;
    else if (off == 19'd1) rd = m_bl;
    else if (off >= 19'd2 && off < 19'd10) rd = {4'h0, m_br[idx]};
    for (int i = 0; i < 8; i++) begin
      duty = (m_br[i] == 4'hF) ? 1'b1 : (m_pwm < m_br[i]);
      m_leds[i] = m_en[i] & duty & ~(m_bl[i] & m_blk[5]);
    end
    m_dout = rd;
    m_pwm  = m_pwm + 4'd1;
    m_blk  = m_blk + 6'd1;
    if (w) begin
      if (off == 19'd0) m_en = d;
      else if (off == 19'd1) m_bl = d;
      else if (off >= 19'd2 && off < 19'd10) m_br[idx] = d[3:0];
    end
  endtask

  // Drive one cycle, predict its outcome, then compare once the edge has passed.
  task automatic drive(input logic r, input logic [18:0] a, input logic w, input logic [7:0] d);
    logic [15:0] exp;
    reset = r; address = a; write_en = w; data_in = d;
    model_step(r, a, w, d);
    exp_q.push_back({m_dout, m_leds});
    @(posedge clock);
    #1;
    exp = exp_q.pop_front();
    check_eq("sb_dout", data_out, exp[15:8]);
    check_eq("sb_leds", leds, exp[7:0]);
  endtask

  task automatic wr(input logic [18:0] a, input logic [7:0] d);
    drive(1'b0, a, 1'b1, d);
  endtask

  task automatic rd(input logic [18:0] a);
    drive(1'b0, a, 1'b0, 8'h00);
  endtask

  int c0, c1, first_hi;

  initial begin
    reset = 1'b1; address = 19'h5c00; write_en = 1'b0; data_in = 8'h00;

    // Reset, then enable all at reset brightness.
    drive(1'b1, 19'h5c00, 1'b0, 8'h00);
    check_eq("rst_dout0", data_out, 8'h00);
    drive(1'b1, 19'h5c00, 1'b0, 8'h00);
    check_eq("rst_dout1", data_out, 8'h00);
    check_eq("rst_leds", leds, 8'h00);
    wr(19'h5c00, 8'hFF);
    rd(19'h5c00);
    check_eq("full_on", leds, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      rd(19'h5c00);
      check_eq("full_on_hold", leds, 8'hFF);
    end

    // Readback of each register class plus unmapped addresses.
    wr(19'h5c00, 8'hA5);
    wr(19'h5c01, 8'h3C);
    wr(19'h5c04, 8'h17);
    rd(19'h5c00); check_eq("rb_enable", data_out, 8'hA5);
    rd(19'h5c01); check_eq("rb_blink", data_out, 8'h3C);
    rd(19'h5c04); check_eq("rb_bright2", data_out, 8'h07);
    rd(19'h5c0A); check_eq("rb_past_end", data_out, 8'h00);
    rd(19'h1234); check_eq("rb_unmapped", data_out, 8'h00);

    // PWM duty at brightness 4, then 0.
    wr(19'h5c01, 8'h00);
    wr(19'h5c00, 8'h01);
    wr(19'h5c02, 8'h04);
    rd(19'h5c00);
    c0 = 0;
    for (int i = 0; i < 64; i++) begin
      rd(19'h5c00);
      c0 += int'(leds[0]);
    end
    check_eq("pwm_b4_count", 8'(c0), 8'd16);
    wr(19'h5c02, 8'h00);
    rd(19'h5c00);
    c0 = 0;
    for (int i = 0; i < 32; i++) begin
      rd(19'h5c00);
      c0 += int'(leds[0]);
    end
    check_eq("pwm_b0_count", 8'(c0), 8'd0);

    // Blink on LED1 only, both at full brightness.
    wr(19'h5c00, 8'h03);
    wr(19'h5c01, 8'h02);
    wr(19'h5c02, 8'h0F);
    rd(19'h5c00);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 64; i++) begin
      rd(19'h5c00);
      c0 += int'(leds[0]);
      c1 += int'(leds[1]);
    end
    check_eq("blink_led0", 8'(c0), 8'd64);
    check_eq("blink_led1", 8'(c1), 8'd32);

    // Write and read of the same register on one edge.
    wr(19'h5c00, 8'h11);
    wr(19'h5c00, 8'h22);
    check_eq("coll_old", data_out, 8'h11);
    rd(19'h5c00);
    check_eq("coll_new", data_out, 8'h22);

    // Reset while active with a concurrent write.
    wr(19'h5c00, 8'hFF);
    wr(19'h5c01, 8'h0F);
    drive(1'b1, 19'h5c00, 1'b1, 8'h55);
    check_eq("rst_act_leds", leds, 8'h00);
    check_eq("rst_act_dout", data_out, 8'h00);
    rd(19'h5c00); check_eq("rst_act_enable", data_out, 8'h00);
    rd(19'h5c02); check_eq("rst_act_bright", data_out, 8'h0F);
    wr(19'h5c00, 8'h01);
    wr(19'h5c02, 8'h01);
    first_hi = 0;
    for (int j = 5; j <= 20; j++) begin
      rd(19'h5c00);
      if (leds[0] && first_hi == 0) first_hi = j;
    end
    check_eq("pwm_restart", 8'(first_hi), 8'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
